// File: rtl/paged_cache_ram_if.sv
// Port bundle for paged_cache_ram: two core load/store ports, the backing-store
// word bus, and flush/status signals. The slave modport is the memory itself.
interface paged_cache_ram_if #(
  parameter int WIDTHAD = 32,
  parameter int WIDTH   = 32
);
  logic [WIDTHAD-1:0] a_addr;
  logic [WIDTHAD-1:0] b_addr;
  logic               a_rden;
  logic               b_rden;
  logic               a_wren;
  logic               b_wren;
  logic [WIDTH-1:0]   a_data;
  logic [WIDTH-1:0]   b_data;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               a_ready;
  logic               b_ready;

  logic               bs_req;
  logic               bs_we;
  logic [WIDTHAD-1:0] bs_addr;
  logic [WIDTH-1:0]   bs_wdata;
  logic               bs_ack;
  logic [WIDTH-1:0]   bs_rdata;

  logic               flush;
  logic               flush_done;
  logic               busy;
  logic [31:0]        miss_count;

  modport slave (
    input  a_addr, b_addr, a_rden, b_rden, a_wren, b_wren, a_data, b_data,
    output a_q, b_q, a_ready, b_ready,
    output bs_req, bs_we, bs_addr, bs_wdata,
    input  bs_ack, bs_rdata,
    input  flush,
    output flush_done, busy, miss_count
  );

  modport master (
    output a_addr, b_addr, a_rden, b_rden, a_wren, b_wren, a_data, b_data,
    input  a_q, b_q, a_ready, b_ready,
    input  bs_req, bs_we, bs_addr, bs_wdata,
    output bs_ack, bs_rdata,
    output flush,
    input  flush_done, busy, miss_count
  );
endinterface

// File: rtl/paged_cache_ram.sv
// Dual-port paged memory: a few on-chip page slots cache a large backing space,
// with true-LRU replacement, dirty-only write-back and an explicit flush walk.
module paged_cache_ram #(
  parameter int WIDTHAD    = 32,
  parameter int PAGEBITS   = 8,
  parameter int SLOTS_LOG2 = 2,
  parameter int WIDTH      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  paged_cache_ram_if.slave bus
);
  localparam int SLOTS = 1 << SLOTS_LOG2;
  localparam int TAGW  = WIDTHAD - PAGEBITS;
  localparam int WORDS = SLOTS << PAGEBITS;

  typedef logic [SLOTS_LOG2-1:0]            slot_t;
  typedef logic [SLOTS_LOG2:0]              scan_t;
  typedef logic [TAGW-1:0]                  tag_t;
  typedef logic [PAGEBITS-1:0]              off_t;
  typedef logic [SLOTS-1:0][SLOTS_LOG2-1:0] ages_t;

  typedef enum logic [2:0] {
    IDLE, WB, FILL, INSTALL, FLUSH_SCAN, FLUSH_WB
  } state_t;

  logic [WIDTH-1:0] mem [WORDS];
  logic [SLOTS-1:0] valid;
  logic [SLOTS-1:0] dirty;
  tag_t             tags [SLOTS];
  ages_t            age;

  state_t           state;
  slot_t            victim;
  tag_t             wb_tag;
  tag_t             fill_tag;
  off_t             off;
  scan_t            scan_idx;
  logic             flush_pending;

  logic [WIDTH-1:0]   a_q_r, b_q_r;
  logic               bs_req_r, bs_we_r, flush_done_r;
  logic [WIDTHAD-1:0] bs_addr_r;
  logic [WIDTH-1:0]   bs_wdata_r;
  logic [31:0]        miss_count_r;

  // Request decode and combinational tag lookup.
  tag_t  a_tag, b_tag;
  off_t  a_off, b_off;
  logic  a_act, b_act, a_hit, b_hit, a_miss, b_miss, accept;
  slot_t a_slot, b_slot, victim_sel, scan_slot;
  off_t  off_inc;

  assign a_tag     = bus.a_addr[WIDTHAD-1:PAGEBITS];
  assign b_tag     = bus.b_addr[WIDTHAD-1:PAGEBITS];
  assign a_off     = bus.a_addr[PAGEBITS-1:0];
  assign b_off     = bus.b_addr[PAGEBITS-1:0];
  assign a_act     = bus.a_rden | bus.a_wren;
  assign b_act     = bus.b_rden | bus.b_wren;
  assign scan_slot = scan_idx[SLOTS_LOG2-1:0];
  assign off_inc   = off + off_t'(1);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    a_hit  = 1'b0;
    b_hit  = 1'b0;
    a_slot = '0;
    b_slot = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (valid[i] && tags[i] == a_tag) begin
        a_hit  = 1'b1;
        a_slot = slot_t'(i);
      end
      if (valid[i] && tags[i] == b_tag) begin
        b_hit  = 1'b1;
        b_slot = slot_t'(i);
      end
    end
  end

  assign a_miss = a_act & ~a_hit;
  assign b_miss = b_act & ~b_hit;
  // A miss on either port stalls both; an idle port never blocks.
  assign accept = (state == IDLE) && !flush_pending && !a_miss && !b_miss;

  // Victim: lowest-index invalid slot, else the least recently used one.
  always_comb begin
    victim_sel = '0;
    for (int i = 0; i < SLOTS; i++)
      if (age[i] == slot_t'(SLOTS - 1)) victim_sel = slot_t'(i);
    for (int i = SLOTS - 1; i >= 0; i--)
      if (!valid[i]) victim_sel = slot_t'(i);
  end

  function automatic ages_t touch(ages_t ag, slot_t s);
    ages_t r;
    r = ag;
    for (int i = 0; i < SLOTS; i++)
      if (ag[i] < ag[s]) r[i] = ag[i] + slot_t'(1);
    r[s] = '0;
    return r;
  endfunction

  // Port A is applied before port B so B's slot ends up most recent.
  ages_t age_access, age_install;
  always_comb begin
    age_access = age;
    if (a_act) age_access = touch(age_access, a_slot);
    if (b_act) age_access = touch(age_access, b_slot);
    age_install = touch(age, victim);
  end

  // NOTE: page data is deliberately not reset; only the slot metadata is.
  // B is written before A so A's data wins when both hit the same word.
  always_ff @(posedge clk) begin
    if (state == FILL && bus.bs_ack)
      mem[{victim, off}] <= bus.bs_rdata;
    if (accept) begin
      if (bus.b_wren) mem[{b_slot, b_off}] <= bus.b_data;
      if (bus.a_wren) mem[{a_slot, a_off}] <= bus.a_data;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments, so reads of mem
  // and of the slot metadata below see the values from before this edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      valid         <= '0;
      dirty         <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        age[i]  <= slot_t'(i);
        tags[i] <= '0;
      end
      victim        <= '0;
      wb_tag        <= '0;
      fill_tag      <= '0;
      off           <= '0;
      scan_idx      <= '0;
      flush_pending <= 1'b0;
      a_q_r         <= '0;
      b_q_r         <= '0;
      bs_req_r      <= 1'b0;
      bs_we_r       <= 1'b0;
      bs_addr_r     <= '0;
      bs_wdata_r    <= '0;
      flush_done_r  <= 1'b0;
      miss_count_r  <= '0;
    end else begin
      flush_done_r <= 1'b0;
      if (bus.flush && state != IDLE) flush_pending <= 1'b1;

      case (state)
        IDLE: begin
          if (accept) begin
            if (bus.a_rden) a_q_r <= mem[{a_slot, a_off}];
            if (bus.b_rden) b_q_r <= mem[{b_slot, b_off}];
            if (bus.a_wren) dirty[a_slot] <= 1'b1;
            if (bus.b_wren) dirty[b_slot] <= 1'b1;
            age <= age_access;
          end
          if (bus.flush || flush_pending) begin
            state    <= FLUSH_SCAN;
            scan_idx <= '0;
          end else if (a_miss || b_miss) begin
            victim       <= victim_sel;
            wb_tag       <= tags[victim_sel];
            fill_tag     <= a_miss ? a_tag : b_tag;
            off          <= '0;
            miss_count_r <= miss_count_r + 32'd1;
            bs_req_r     <= 1'b1;
            if (valid[victim_sel] && dirty[victim_sel]) begin
              state      <= WB;
              bs_we_r    <= 1'b1;
              bs_addr_r  <= {tags[victim_sel], off_t'(0)};
              bs_wdata_r <= mem[{victim_sel, off_t'(0)}];
            end else begin
              state     <= FILL;
              bs_we_r   <= 1'b0;
              bs_addr_r <= {(a_miss ? a_tag : b_tag), off_t'(0)};
            end
          end
        end

        WB, FLUSH_WB: begin
          if (bus.bs_ack) begin
            if (&off) begin
              off <= '0;
              if (state == WB) begin
                state     <= FILL;
                bs_we_r   <= 1'b0;
                bs_addr_r <= {fill_tag, off_t'(0)};
              end else begin
                dirty[victim] <= 1'b0;
                bs_req_r      <= 1'b0;
                bs_we_r       <= 1'b0;
                scan_idx      <= scan_idx + scan_t'(1);
                state         <= FLUSH_SCAN;
              end
            end else begin
              off        <= off_inc;
              bs_addr_r  <= {wb_tag, off_inc};
              bs_wdata_r <= mem[{victim, off_inc}];
            end
          end
        end

        FILL: begin
          if (bus.bs_ack) begin
            if (&off) begin
              off      <= '0;
              bs_req_r <= 1'b0;
              state    <= INSTALL;
            end else begin
              off       <= off_inc;
              bs_addr_r <= {fill_tag, off_inc};
            end
          end
        end

        INSTALL: begin
          tags[victim]  <= fill_tag;
          valid[victim] <= 1'b1;
          dirty[victim] <= 1'b0;
          age           <= age_install;
          state         <= IDLE;
        end

        FLUSH_SCAN: begin
          if (scan_idx[SLOTS_LOG2]) begin
            flush_done_r  <= 1'b1;
            flush_pending <= 1'b0;
            state         <= IDLE;
          end else if (valid[scan_slot] && dirty[scan_slot]) begin
            victim     <= scan_slot;
            wb_tag     <= tags[scan_slot];
            off        <= '0;
            bs_req_r   <= 1'b1;
            bs_we_r    <= 1'b1;
            bs_addr_r  <= {tags[scan_slot], off_t'(0)};
            bs_wdata_r <= mem[{scan_slot, off_t'(0)}];
            state      <= FLUSH_WB;
          end else begin
            scan_idx <= scan_idx + scan_t'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.a_ready    = accept;
  assign bus.b_ready    = accept;
  assign bus.a_q        = a_q_r;
  assign bus.b_q        = b_q_r;
  assign bus.bs_req     = bs_req_r;
  assign bus.bs_we      = bs_we_r;
  assign bus.bs_addr    = bs_addr_r;
  assign bus.bs_wdata   = bs_wdata_r;
  assign bus.flush_done = flush_done_r;
  assign bus.busy       = (state != IDLE);
  assign bus.miss_count = miss_count_r;
endmodule

// File: doc/paged_cache_ram.md
Name: paged_cache_ram

Overview:
Dual-port, word-addressed paged memory. A small on-chip page store caches pages of a large backing address space. Replacement is true LRU, and only dirty pages are written back. Backing storage sits behind a generic one-word request/acknowledge bus. An explicit flush command writes back all dirty pages. The block sits between the core's load/store ports and the memory/filesystem bridge, as the next-generation paged RAM.

Parameters:
WIDTHAD, 32, width of the virtual word address on ports A/B and the backing bus
PAGEBITS, 8, log2 of words per page (offset field = addr[PAGEBITS-1:0]; tag = addr[WIDTHAD-1:PAGEBITS])
SLOTS_LOG2, 2, log2 of the number of on-chip page slots (SLOTS = 1<<SLOTS_LOG2)
WIDTH, 32, data word width

Ports:
clk  in  1  single clock; all state updates on the rising edge
rst_n  in  1  synchronous, active-low reset
a_addr, b_addr  in  WIDTHAD  word address per port
a_rden, b_rden  in  1  read request
a_wren, b_wren  in  1  write request (wren and rden together = write plus read-before-write)
a_data, b_data  in  WIDTH  write data
a_q, b_q  out  WIDTH  read data, valid 1 cycle after an accepted read
a_ready, b_ready  out  1  request accepted this cycle
bs_req  out  1  backing-store word request
bs_we  out  1  1 = write, 0 = read
bs_addr  out  WIDTHAD  backing word address = {tag, offset}
bs_wdata  out  WIDTH  write data
bs_ack  in  1  backing store completes the current word this cycle
bs_rdata  in  WIDTH  read data, valid when bs_ack=1 and bs_we=0
flush  in  1  request write-back of all dirty pages
flush_done  out  1  one-cycle pulse when a flush completes
busy  out  1  FSM not in IDLE
miss_count  out  32  misses serviced, wraps modulo 2^32

Behaviour:
- Reset (rst_n=0 at an edge): all slots valid=0 and dirty=0. LRU ages are set to age[i]=i, so slot 0 is MRU. FSM goes to IDLE. Outputs: bs_req=0, bs_we=0, bs_addr=0, bs_wdata=0, a_q=b_q=0, flush_done=0, miss_count=0, flush_pending=0. Reset mid-transfer abandons the transfer: bs_req is 0 after that edge, with no write-back. Page data RAM contents are don't-care.
- Lookup is combinational: a hit means some slot has valid=1 and tag equal to the request tag. At most one slot can match.
- ready rule: x_ready=1 iff FSM==IDLE, no flush is pending, and every active request (rden|wren) on either port hits. An idle port (no request) never blocks the other port. A miss on either port deasserts both readies (global stall).
- Accepted write: word committed at that edge and the slot's dirty bit set. Accepted read: x_q is presented the next cycle and holds until the next accepted read.
- Same-word collision: if A and B write the same word in the same cycle, A's data wins. If a read and a write hit the same word in the same cycle, the read returns old data.
- LRU update on each accepted access: touched slot age=0; slots whose age was below the touched slot's old age increment by 1. If both ports touch different slots, apply A then B, so B's slot ends MRU. Victim is the lowest-index invalid slot; otherwise the slot with age SLOTS-1.
- FSM: IDLE -> WB -> FILL -> INSTALL -> IDLE; and IDLE -> FLUSH_SCAN <-> FLUSH_WB -> IDLE.
- IDLE, with flush or flush_pending set: go to FLUSH_SCAN. Flush takes priority over misses.
- IDLE, on a miss: service port A's miss if A misses, else B's. Latch the victim and the new tag. Go to WB if the victim is valid and dirty, else to FILL. Increment miss_count.
- WB: stream offsets 0..2^PAGEBITS-1 with bs_we=1, one word per bs_ack. bs_req stays high with addr/wdata stable until ack. The next word may be driven the cycle after the ack. After the last ack, go to FILL.
- FILL: same streaming with bs_we=0. bs_rdata is written into the victim slot at each ack. After the last ack, go to INSTALL.
- INSTALL (1 cycle): victim tag written, valid=1, dirty=0, and victim made MRU. Return to IDLE. The stalled request retries the next cycle and hits. If both ports missed on the same tag, both hit after this one fill.
- flush asserted outside IDLE sets flush_pending, which is serviced at the next IDLE.
- FLUSH_SCAN: walk slots in ascending index. A valid and dirty slot goes to FLUSH_WB, which writes back the whole page, clears dirty (valid kept), and returns to scan the next slot. After the last slot: flush_done=1 for one cycle, flush_pending cleared, return to IDLE.
- Address arithmetic: bs_addr = {tag, offset}. The offset counter is PAGEBITS wide, and the last word is detected at all-ones before wrap.

Test Plan:
- With PAGEBITS=2, SLOTS_LOG2=1 and bs_ack=1 always: read 0x10 cold -> 4 reads at 0x10..0x13, no writes, miss_count=1; a_q=bs data for 0x10 two cycles after INSTALL.
- Write 0xAA to 0x10, then touch tags 0x20 and 0x30 -> the page at 0x10 is evicted with 4 writes at 0x10..0x13 carrying 0xAA at 0x10. A clean evicted page produces 0 writes.
- LRU check: access tags 1, 2, 1, then tag 3 -> the tag-2 slot is evicted; tag 1 still hits with no bs traffic.
- Hold bs_ack low 5 cycles per word during FILL -> bs_req/bs_addr stay stable, both readies stay 0, data is correct after fill.
- Both ports miss on 0x40 and 0x41 in the same cycle -> exactly one fill; both ready the cycle after INSTALL. A and B write 1 and 2 to 0x40 in the same cycle -> a later read returns 1.
- Pulse flush with 2 dirty slots -> 8 writes, then flush_done one cycle, dirty bits cleared, pages still hit. Assert rst_n=0 mid-WB -> bs_req=0 next cycle and all accesses miss afterwards.
